// File: rtl/utils.sv
// Shared types and constants for the boot-time program loader.
package utils;

  localparam int         CLK_PER_HALF_BIT = 434;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'h99;
  localparam logic [7:0] LOADER_ACK_BYTE  = 8'hAA;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN,
    DATA,
    ACK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/byte_to_word_asm.sv
// Little-endian 8->32 assembler; word_valid pulses the cycle after the 4th strobe.
module byte_to_word_asm (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  byte_in,
  input  logic        strobe,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
      end else if (strobe) begin
        // shifting in from the top leaves the first byte in [7:0] after four strobes
        word <= {byte_in, word[31:8]};
        cnt  <= cnt + 2'd1;
        if (cnt == 2'd3) word_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: sync byte, 32-bit word count, then little-endian words to instruction memory, then ACK.
//
// state     | meaning
// WAIT_SYNC | idle, looking for the sync byte
// LEN       | collecting the 4-byte word count
// DATA      | collecting words and writing them out
// ACK       | waiting for the transmitter to accept the ACK byte
// DONE      | load complete, terminal until reset
// ERROR     | load aborted, terminal until reset
module uart_loader
  import utils::*;
#(
  parameter int         CLK_PER_HALF_BIT = utils::CLK_PER_HALF_BIT,
  parameter int         ADDR_W           = 14,
  parameter logic [7:0] SYNC_BYTE        = LOADER_SYNC_BYTE,
  parameter logic [7:0] ACK_BYTE         = LOADER_ACK_BYTE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_ferr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [31:0]   CAPACITY = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  loader_state_t     state, state_n;
  logic              rx_prev;
  logic              byte_ev;
  logic              ferr_ev;
  logic [31:0]       count_q;
  logic [ADDR_W:0]   word_idx;
  logic [7:0]        tx_data_q;
  logic [31:0]       asm_word;
  logic              asm_valid;
  logic              asm_strobe;
  logic              asm_clear;
  logic              load_count;
  logic              idx_clr;
  logic              idx_inc;
  logic [31:0]       idx_next;

  assign byte_ev    = rx_valid & ~rx_prev;
  assign ferr_ev    = byte_ev & rx_ferr;
  assign asm_strobe = byte_ev & ~rx_ferr & ((state == LEN) | (state == DATA));
  assign asm_clear  = (state == WAIT_SYNC);
  assign idx_next   = 32'(word_idx) + 32'd1;

  byte_to_word_asm u_asm (
    .clk        (clk),
    .rstn       (rstn),
    .byte_in    (rx_data),
    .strobe     (asm_strobe),
    .clear      (asm_clear),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= WAIT_SYNC;
      rx_prev   <= 1'b0;
      count_q   <= '0;
      word_idx  <= '0;
      tx_data_q <= '0;
    end else begin
      state   <= state_n;
      rx_prev <= rx_valid;
      if (load_count) count_q <= asm_word;
      if (idx_clr)      word_idx <= '0;
      else if (idx_inc) word_idx <= word_idx + IDX_ONE;
      if (tx_start) tx_data_q <= ACK_BYTE;
    end
  end

  always_comb begin
    state_n    = state;
    tx_start   = 1'b0;
    mem_we     = 1'b0;
    load_count = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (ferr_ev)                                state_n = ERROR;
        else if (byte_ev && rx_data == SYNC_BYTE)   state_n = LEN;
      end
      LEN: begin
        if (ferr_ev) begin
          state_n = ERROR;
        end else if (asm_valid) begin
          load_count = 1'b1;
          idx_clr    = 1'b1;
          if (asm_word == 32'd0)         state_n = ACK;
          else if (asm_word > CAPACITY)  state_n = ERROR;
          else                           state_n = DATA;
        end
      end
      DATA: begin
        // a framing error wins over a write landing in the same cycle
        if (ferr_ev) begin
          state_n = ERROR;
        end else if (asm_valid) begin
          mem_we  = 1'b1;
          idx_inc = 1'b1;
          if (idx_next == count_q) state_n = ACK;
        end
      end
      ACK: begin
        if (ferr_ev) begin
          state_n = ERROR;
        end else if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = DONE;
      ERROR:   state_n = ERROR;
      default: state_n = ERROR;
    endcase
  end

  assign tx_data   = tx_start ? ACK_BYTE : tx_data_q;
  assign mem_addr  = word_idx[ADDR_W-1:0];
  assign mem_wdata = asm_word;
  assign done      = (state == DONE);
  assign err       = (state == ERROR);

endmodule
